// File: rtl/jtag_host_sequencer.sv
// jtag_host_sequencer
//   On-board JTAG host. Accepts scan commands (TAP reset, IR scan, DR scan, idle run), drives the
//   TCK/TMS/TDI waveform for each and returns the TDO bits captured during the shift phase.
//
//   Ports
//     clk_i        system clock, all logic on the rising edge
//     rst_i        synchronous active-high reset; aborts any command and replays a TAP reset
//     cmd_valid_i  command offered
//     cmd_ready_o  sequencer idle; command accepted when cmd_valid_i && cmd_ready_o
//     cmd_op_i     00 TAP_RESET, 01 IR_SCAN, 10 DR_SCAN, 11 RUN_IDLE
//     cmd_len_i    scan bits (IR/DR) or idle ticks (RUN_IDLE); clamped to MaxLen
//     cmd_data_i   TDI bits, bit 0 shifted first
//     rsp_valid_o  one-cycle pulse when a command finishes
//     rsp_data_o   captured TDO bits, bit 0 first captured; held until the next response
//     busy_o       inverse of cmd_ready_o
//     tck_o        JTAG clock, registered
//     tms_o        JTAG mode select, registered, changes only at tick start
//     tdi_o        JTAG data out, registered, changes only at tick start
//     tdo_i        JTAG data in, sampled in the clock cycle where tck_o rises
module jtag_host_sequencer #(
    parameter int unsigned ClkDiv = 4,
    parameter int unsigned MaxLen = 16,
    parameter int unsigned LenW   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LenW-1:0]   cmd_len_i,
    input  logic [MaxLen-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    output logic [MaxLen-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i
);

    localparam int unsigned PhW  = (2 * ClkDiv > 1) ? $clog2(2 * ClkDiv) : 1;
    // Tick counter must cover both the 6-tick reset header and a full-length segment.
    localparam int unsigned CntW = (LenW > 3) ? LenW : 3;
    localparam int unsigned IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;

    localparam logic [PhW-1:0] PhLast = PhW'(2 * ClkDiv - 1);
    localparam logic [PhW-1:0] PhRise = PhW'(ClkDiv);

    localparam logic [1:0] OpTapReset = 2'b00;
    localparam logic [1:0] OpIrScan   = 2'b01;
    localparam logic [1:0] OpDrScan   = 2'b10;
    localparam logic [1:0] OpRunIdle  = 2'b11;

    typedef enum logic [2:0] {
        StRstSeq,
        StIdle,
        StHdr,
        StShift,
        StTail,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [PhW-1:0]    phase_q, phase_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [MaxLen-1:0] data_q, data_d;
    logic [MaxLen-1:0] cap_q, cap_d;
    logic [MaxLen-1:0] rsp_data_q, rsp_data_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;

    logic [LenW-1:0]   len_in;
    logic [CntW-1:0]   seg_len;

    // Header tick count; RUN_IDLE is carried entirely by the header segment.
    function automatic logic [CntW-1:0] hdr_len(input logic [1:0] op, input logic [LenW-1:0] len);
        logic [CntW-1:0] n;
        unique case (op)
            OpTapReset: n = CntW'(6);
            OpIrScan:   n = CntW'(4);
            OpDrScan:   n = CntW'(3);
            default:    n = CntW'(len);
        endcase
        return n;
    endfunction

    // TMS value for tick cnt of the given segment.
    function automatic logic tick_tms(input state_e st, input logic [1:0] op,
                                      input logic [CntW-1:0] cnt, input logic [CntW-1:0] len);
        logic tms;
        tms = 1'b0;
        case (st)
            StRstSeq: tms = (cnt < CntW'(5));
            StHdr: begin
                case (op)
                    OpTapReset: tms = (cnt < CntW'(5));
                    OpIrScan:   tms = (cnt < CntW'(2));
                    OpDrScan:   tms = (cnt == '0);
                    default:    tms = 1'b0;
                endcase
            end
            StShift: tms = (cnt == len - CntW'(1));
            StTail:  tms = (cnt == '0);
            default: tms = 1'b0;
        endcase
        return tms;
    endfunction

    assign len_in = (cmd_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : cmd_len_i;

    always_comb begin
        unique case (state_q)
            StRstSeq: seg_len = CntW'(6);
            StHdr:    seg_len = hdr_len(op_q, len_q);
            StShift:  seg_len = CntW'(len_q);
            default:  seg_len = CntW'(2);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        len_d      = len_q;
        data_d     = data_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                phase_d = '0;
                cnt_d   = '0;
                tck_d   = 1'b0;
                tms_d   = 1'b0;
                tdi_d   = 1'b0;
                if (cmd_valid_i) begin
                    op_d   = cmd_op_i;
                    len_d  = len_in;
                    data_d = cmd_data_i;
                    cap_d  = '0;
                    if (cmd_op_i != OpTapReset && len_in == '0) begin
                        // Nothing to clock: respond in the very next cycle.
                        state_d    = StDone;
                        rsp_data_d = '0;
                    end else begin
                        state_d = StHdr;
                        tms_d   = tick_tms(StHdr, cmd_op_i, '0, CntW'(len_in));
                    end
                end
            end
            default: begin
                phase_d = (phase_q == PhLast) ? '0 : phase_q + PhW'(1);
                tck_d   = (phase_d >= PhRise);
                // First cycle with TCK high is the rising-edge cycle.
                if (state_q == StShift && phase_q == PhRise) begin
                    cap_d[cnt_q[IdxW-1:0]] = tdo_i;
                end
                if (phase_q == PhLast) begin
                    if (state_q == StShift) begin
                        data_d = data_q >> 1;
                    end
                    if (cnt_q != seg_len - CntW'(1)) begin
                        cnt_d = cnt_q + CntW'(1);
                    end else begin
                        cnt_d = '0;
                        unique case (state_q)
                            StRstSeq: state_d = StIdle;
                            StHdr: begin
                                state_d = (op_q == OpIrScan || op_q == OpDrScan) ? StShift : StDone;
                            end
                            StShift:  state_d = StTail;
                            default:  state_d = StDone;
                        endcase
                    end
                    if (state_d == StIdle || state_d == StDone) begin
                        tms_d = 1'b0;
                        tdi_d = 1'b0;
                        if (state_d == StDone) begin
                            rsp_data_d = cap_q;
                        end
                    end else begin
                        tms_d = tick_tms(state_d, op_q, cnt_d, CntW'(len_q));
                        tdi_d = (state_d == StShift) & data_d[0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Reset state doubles as tick 0 of the automatic TAP reset sequence.
            state_q    <= StRstSeq;
            phase_q    <= '0;
            cnt_q      <= '0;
            op_q       <= OpTapReset;
            len_q      <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            len_q      <= len_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
        end
    end

    assign cmd_ready_o = (state_q == StIdle) || (state_q == StDone);
    assign busy_o      = ~cmd_ready_o;
    assign rsp_valid_o = (state_q == StDone);
    assign rsp_data_o  = rsp_data_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_host_sequencer.sv
// Directed bench for jtag_host_sequencer. A behavioural target returns TDI (optionally inverted)
// on TDO while TCK is high and the complement while TCK is low, so capture on the wrong phase
// shows up in the response. Expected responses are queued when a command is issued and popped
// when the response pulse arrives.
module tb_jtag_host_sequencer;

    localparam int unsigned ClkDiv = 2;
    localparam int unsigned MaxLen = 16;
    localparam int unsigned LenW   = 5;

    localparam logic [1:0] OpTapReset = 2'b00;
    localparam logic [1:0] OpIrScan   = 2'b01;
    localparam logic [1:0] OpDrScan   = 2'b10;
    localparam logic [1:0] OpRunIdle  = 2'b11;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              cmd_valid = 1'b0;
    logic [1:0]        cmd_op    = '0;
    logic [LenW-1:0]   cmd_len   = '0;
    logic [MaxLen-1:0] cmd_data  = '0;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [MaxLen-1:0] rsp_data;
    logic              busy;
    logic              tck;
    logic              tms;
    logic              tdi;
    logic              tdo;
    logic              tdo_inv   = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [MaxLen-1:0] rsp;
        int                lat;
        int                n;
        logic [63:0]       tms;
        logic [63:0]       tdi;
    } exp_t;

    exp_t sb_q[$];

    jtag_host_sequencer #(
        .ClkDiv(ClkDiv),
        .MaxLen(MaxLen),
        .LenW  (LenW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i   (cmd_op),
        .cmd_len_i  (cmd_len),
        .cmd_data_i (cmd_data),
        .rsp_valid_o(rsp_valid),
        .rsp_data_o (rsp_data),
        .busy_o     (busy),
        .tck_o      (tck),
        .tms_o      (tms),
        .tdi_o      (tdi),
        .tdo_i      (tdo)
    );

    always #5 clk = ~clk;

    assign tdo = tck ? (tdi ^ tdo_inv) : ~(tdi ^ tdo_inv);

    // Log TMS/TDI at every TCK rising edge.
    logic tms_log [0:4095];
    logic tdi_log [0:4095];
    int   tick_total = 0;
    logic tck_prev   = 1'b0;

    always @(negedge clk) begin
        if (tck && !tck_prev) begin
            if (tick_total < 4096) begin
                tms_log[tick_total] <= tms;
                tdi_log[tick_total] <= tdi;
            end
            tick_total <= tick_total + 1;
        end
        tck_prev <= tck;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input int len,
                                   input logic [MaxLen-1:0] data, input logic inv);
        exp_t e;
        int   l;
        int   n;
        l     = (len > int'(MaxLen)) ? int'(MaxLen) : len;
        n     = 0;
        e.tms = '0;
        e.tdi = '0;
        e.rsp = '0;
        case (op)
            OpTapReset: begin
                for (int i = 0; i < 6; i++) begin
                    e.tms[n] = (i < 5);
                    n++;
                end
            end
            OpRunIdle: n = l;
            default: begin
                if (l > 0) begin
                    if (op == OpIrScan) begin
                        for (int i = 0; i < 4; i++) begin
                            e.tms[n] = (i < 2);
                            n++;
                        end
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            e.tms[n] = (i == 0);
                            n++;
                        end
                    end
                    for (int i = 0; i < l; i++) begin
                        e.tms[n] = (i == l - 1);
                        e.tdi[n] = data[i];
                        e.rsp[i] = data[i] ^ inv;
                        n++;
                    end
                    e.tms[n] = 1'b1;
                    n++;
                    e.tms[n] = 1'b0;
                    n++;
                end
            end
        endcase
        e.n   = n;
        e.lat = 1 + 2 * int'(ClkDiv) * n;
        return e;
    endfunction

    // Issue one command; returns the tick log index at acceptance. Ends at the cycle-1 negedge.
    task automatic start_cmd(input string name, input logic [1:0] op, input int len,
                             input logic [MaxLen-1:0] data, input logic inv, output int t0);
        int w;
        w = 0;
        while (!cmd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk({name, ".ready_before"}, 64'(cmd_ready), 64'd1);
        tdo_inv = inv;
        sb_q.push_back(model(op, len, data, inv));
        cmd_op    = op;
        cmd_len   = LenW'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        t0        = tick_total;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_data  = ~data;
    endtask

    task automatic finish_cmd(input string name, input int t0, input bit poke);
        exp_t        e;
        int          k;
        logic [63:0] obs_tms;
        logic [63:0] obs_tdi;
        e = sb_q.pop_front();
        k = 1;
        chk({name, ".ready_cycle1"}, 64'(cmd_ready), 64'(e.n == 0));
        while (!rsp_valid && k < 1000) begin
            if (poke) begin
                cmd_valid = (k >= 2 && k < 8);
                cmd_op    = OpTapReset;
                cmd_len   = LenW'(5);
            end
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b0;
        chk({name, ".latency"}, 64'(k), 64'(e.lat));
        chk({name, ".ready_at_rsp"}, 64'(cmd_ready), 64'd1);
        chk({name, ".busy_at_rsp"}, 64'(busy), 64'd0);
        chk({name, ".rsp_data"}, 64'(rsp_data), 64'(e.rsp));
        chk({name, ".ticks"}, 64'(tick_total - t0), 64'(e.n));
        obs_tms = '0;
        obs_tdi = '0;
        for (int i = 0; i < e.n && i < 64 && t0 + i < 4096; i++) begin
            obs_tms[i] = tms_log[t0 + i];
            obs_tdi[i] = tdi_log[t0 + i];
        end
        chk({name, ".tms_seq"}, obs_tms, e.tms);
        chk({name, ".tdi_seq"}, obs_tdi, e.tdi);
        @(negedge clk);
        chk({name, ".rsp_pulse"}, 64'(rsp_valid), 64'd0);
        chk({name, ".rsp_held"}, 64'(rsp_data), 64'(e.rsp));
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input int len,
                           input logic [MaxLen-1:0] data, input logic inv, input bit poke);
        int t0;
        start_cmd(name, op, len, data, inv, t0);
        finish_cmd(name, t0, poke);
    endtask

    // Hold reset for 'hold' sampling edges, then check the automatic TAP reset sequence.
    task automatic reset_seq(input string name, input int hold);
        int          k;
        int          t0;
        int          pulses;
        logic [63:0] obs_tms;
        rst = 1'b1;
        repeat (hold) @(negedge clk);
        chk({name, ".rst_tck"}, 64'(tck), 64'd0);
        chk({name, ".rst_tms"}, 64'(tms), 64'd1);
        chk({name, ".rst_tdi"}, 64'(tdi), 64'd0);
        chk({name, ".rst_ready"}, 64'(cmd_ready), 64'd0);
        chk({name, ".rst_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({name, ".rst_rsp_data"}, 64'(rsp_data), 64'd0);
        rst    = 1'b0;
        t0     = tick_total;
        k      = 1;
        pulses = 0;
        while (!cmd_ready && k < 1000) begin
            @(negedge clk);
            k++;
            if (rsp_valid) pulses++;
        end
        chk({name, ".ready_cycle"}, 64'(k), 64'(1 + 2 * ClkDiv * 6));
        chk({name, ".no_rsp"}, 64'(pulses), 64'd0);
        chk({name, ".ticks"}, 64'(tick_total - t0), 64'd6);
        obs_tms = '0;
        for (int i = 0; i < 6 && t0 + i < 4096; i++) obs_tms[i] = tms_log[t0 + i];
        chk({name, ".tms_seq"}, obs_tms, 64'h1f);
        chk({name, ".idle_tms"}, 64'(tms), 64'd0);
    endtask

    initial begin
        int t0;
        int pulses;
        int not_ready;

        @(negedge clk);
        reset_seq("por", 3);

        run_cmd("ir_sample", OpIrScan, 4, 16'h0001, 1'b0, 1'b0);
        run_cmd("dr_bsr9", OpDrScan, 9, 16'h012d, 1'b1, 1'b0);
        run_cmd("ir_intest", OpIrScan, 4, 16'h0003, 1'b0, 1'b0);
        run_cmd("run_idle3", OpRunIdle, 3, 16'hffff, 1'b0, 1'b0);
        run_cmd("dr_loop16", OpDrScan, 16, 16'ha5c3, 1'b0, 1'b0);
        run_cmd("dr_clamp20", OpDrScan, 20, 16'h3c5a, 1'b1, 1'b0);
        run_cmd("tap_reset", OpTapReset, 7, 16'hbeef, 1'b0, 1'b0);
        run_cmd("ir_len0", OpIrScan, 0, 16'hffff, 1'b0, 1'b0);
        run_cmd("idle_len0", OpRunIdle, 0, 16'h1234, 1'b0, 1'b0);

        // Commands offered while busy must be dropped, not queued.
        run_cmd("dr_poke", OpDrScan, 8, 16'h00c6, 1'b0, 1'b1);
        pulses    = 0;
        not_ready = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (!cmd_ready) not_ready++;
        end
        chk("poke.no_extra_rsp", 64'(pulses), 64'd0);
        chk("poke.stays_idle", 64'(not_ready), 64'd0);

        // Abort a DR scan mid-shift while TCK is high (tick 5, phase 2 -> cycle 23).
        start_cmd("abort", OpDrScan, 8, 16'h0055, 1'b0, t0);
        repeat (22) @(negedge clk);
        chk("abort.busy_mid_shift", 64'(busy), 64'd1);
        chk("abort.tck_high", 64'(tck), 64'd1);
        void'(sb_q.pop_back());
        reset_seq("abort", 1);

        run_cmd("after_abort", OpDrScan, 5, 16'h0016, 1'b1, 1'b0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
